// File: rtl/sockit_spi_pkg.sv
// ---------------------------------------------------------------------------
// sockit_spi_pkg
// Shared definitions for the sockit SPI bus-side blocks.
//   - arb_state_t : arbiter state encoding (ARB_IDLE, ARB_OWN0, ARB_OWN1)
//   - req_valid() : a requester is active when it strobes read or write
//   - BAW_DEF     : default bus address width
// No ports (package).
// ---------------------------------------------------------------------------
package sockit_spi_pkg;

  localparam int BAW_DEF = 24;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic logic req_valid(input logic wen, input logic ren);
    return wen | ren;
  endfunction

endpackage

// File: rtl/sockit_spi_arb.sv
// ---------------------------------------------------------------------------
// sockit_spi_arb
// Two-requester arbiter in front of the shared SPI bus-side port.
// m0 = register/CPU requester, m1 = XIP fetch requester. The owner is held
// in a registered FSM; the loser is stalled with its wait request, and a
// per-grant completion budget forces a handover when the other side waits.
//
// Build option: SOCKIT_SPI_ARB_RR_EN
//   defined     -> round-robin: IDLE ties go to the requester that did not
//                  own the bus last, budget release applies to both owners.
//   not defined -> fixed priority: m0 wins IDLE ties and is never forced
//                  off the bus by the budget; only m1 is.
//
// Parameters: BAW   bus address width
//             BURST completions per grant while the other side waits (>=1)
// Ports:
//   clk, rst (synchronous, active-low)
//   m0_/m1_ wen, ren, adr, wdt   requester strobes/address/write data
//   m0_/m1_ rdt, wrq             read data (copy of bso_rdt), wait request
//   bso_ wen, ren, adr, wdt      shared-bus outputs
//   bso_ rdt, wrq                shared-bus read data and wait request
//   arb_gnt                      one-hot owner, bit0 = m0, bit1 = m1
// ---------------------------------------------------------------------------
module sockit_spi_arb
  import sockit_spi_pkg::*;
#(
  parameter int BAW   = BAW_DEF,
  parameter int BURST = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           m0_wen,
  input  logic           m0_ren,
  input  logic [BAW-1:0] m0_adr,
  input  logic [31:0]    m0_wdt,
  output logic [31:0]    m0_rdt,
  output logic           m0_wrq,
  input  logic           m1_wen,
  input  logic           m1_ren,
  input  logic [BAW-1:0] m1_adr,
  input  logic [31:0]    m1_wdt,
  output logic [31:0]    m1_rdt,
  output logic           m1_wrq,
  output logic           bso_wen,
  output logic           bso_ren,
  output logic [BAW-1:0] bso_adr,
  output logic [31:0]    bso_wdt,
  input  logic [31:0]    bso_rdt,
  input  logic           bso_wrq,
  output logic [1:0]     arb_gnt
);

  localparam int             CW      = (BURST > 1) ? $clog2(BURST) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(BURST - 1);

`ifdef SOCKIT_SPI_ARB_RR_EN
  localparam logic BUDGET0 = 1'b1;
`else
  // m0 keeps the bus for as long as it keeps requesting.
  localparam logic BUDGET0 = 1'b0;
`endif
  localparam logic BUDGET1 = 1'b1;

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          m0_req, m1_req;

  assign m0_req = req_valid(m0_wen, m0_ren);
  assign m1_req = req_valid(m1_wen, m1_ren);

`ifdef SOCKIT_SPI_ARB_RR_EN
  // Last owner; 1 after reset so the first tie goes to m0.
  logic rr_q, rr_d;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
`ifdef SOCKIT_SPI_ARB_RR_EN
      rr_q    <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef SOCKIT_SPI_ARB_RR_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next state and completion counter
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (m0_req && m1_req) begin
`ifdef SOCKIT_SPI_ARB_RR_EN
          state_d = rr_q ? ARB_OWN0 : ARB_OWN1;
`else
          state_d = ARB_OWN0;
`endif
        end else if (m0_req) begin
          state_d = ARB_OWN0;
        end else if (m1_req) begin
          state_d = ARB_OWN1;
        end
      end
      ARB_OWN0: begin
        if (!m0_req) begin
          cnt_d   = '0;
          state_d = m1_req ? ARB_OWN1 : ARB_IDLE;
        end else if (!bso_wrq) begin
          // Budget exhausted: restart the count whether or not we hand over.
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (BUDGET0 && m1_req) state_d = ARB_OWN1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ARB_OWN1: begin
        if (!m1_req) begin
          cnt_d   = '0;
          state_d = m0_req ? ARB_OWN0 : ARB_IDLE;
        end else if (!bso_wrq) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            if (BUDGET1 && m0_req) state_d = ARB_OWN0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef SOCKIT_SPI_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (state_d == ARB_OWN0 && state_q != ARB_OWN0) rr_d = 1'b0;
    if (state_d == ARB_OWN1 && state_q != ARB_OWN1) rr_d = 1'b1;
  end
`endif

  // -------------------------------------------------------------------------
  // Bus mux and wait requests: registered owner plus live inputs
  // -------------------------------------------------------------------------
  always_comb begin
    bso_wen = 1'b0;
    bso_ren = 1'b0;
    bso_adr = '0;
    bso_wdt = '0;
    arb_gnt = 2'b00;
    m0_wrq  = m0_req;
    m1_wrq  = m1_req;
    case (state_q)
      ARB_OWN0: begin
        bso_wen = m0_wen;
        bso_ren = m0_ren;
        bso_adr = m0_adr;
        bso_wdt = m0_wdt;
        arb_gnt = 2'b01;
        m0_wrq  = bso_wrq;
      end
      ARB_OWN1: begin
        bso_wen = m1_wen;
        bso_ren = m1_ren;
        bso_adr = m1_adr;
        bso_wdt = m1_wdt;
        arb_gnt = 2'b10;
        m1_wrq  = bso_wrq;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the completing requester consumes it.
  assign m0_rdt = bso_rdt;
  assign m1_rdt = bso_rdt;

endmodule

// File: tb/tb_sockit_spi_arb.sv
module tb_sockit_spi_arb;

  localparam int BAW   = 24;
  localparam int BURST = 4;
`ifdef SOCKIT_SPI_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           m0_wen, m0_ren, m1_wen, m1_ren;
  logic [BAW-1:0] m0_adr, m1_adr;
  logic [31:0]    m0_wdt, m1_wdt;
  logic [31:0]    m0_rdt, m1_rdt;
  logic           m0_wrq, m1_wrq;
  logic           bso_wen, bso_ren;
  logic [BAW-1:0] bso_adr;
  logic [31:0]    bso_wdt;
  logic [31:0]    bso_rdt;
  logic           bso_wrq;
  logic [1:0]     arb_gnt;

  always #5 clk = ~clk;

  sockit_spi_arb #(.BAW(BAW), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .m0_wen(m0_wen), .m0_ren(m0_ren), .m0_adr(m0_adr), .m0_wdt(m0_wdt),
    .m0_rdt(m0_rdt), .m0_wrq(m0_wrq),
    .m1_wen(m1_wen), .m1_ren(m1_ren), .m1_adr(m1_adr), .m1_wdt(m1_wdt),
    .m1_rdt(m1_rdt), .m1_wrq(m1_wrq),
    .bso_wen(bso_wen), .bso_ren(bso_ren), .bso_adr(bso_adr),
    .bso_wdt(bso_wdt), .bso_rdt(bso_rdt), .bso_wrq(bso_wrq),
    .arb_gnt(arb_gnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus (-1 = nobody), completions used in
  // the current grant, and who owned it last.
  int own  = -1;
  int used = 0;
  int last = 1;
  logic comp0, comp1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit budget(input int x);
    return RR_MODE || (x == 1);
  endfunction

  // One clock cycle: check every output against the model mid-cycle, then
  // advance the model on the rising edge with the inputs that were applied.
  task automatic step();
    logic       r0, r1, ew0, ew1;
    logic [1:0] eg;
    logic [57:0] eb;
    int x;
    @(negedge clk);
    r0 = m0_wen | m0_ren;
    r1 = m1_wen | m1_ren;
    eg = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
    eb = (own == 0) ? {m0_wen, m0_ren, m0_adr, m0_wdt} :
         (own == 1) ? {m1_wen, m1_ren, m1_adr, m1_wdt} : 58'd0;
    ew0 = (own == 0) ? bso_wrq : r0;
    ew1 = (own == 1) ? bso_wrq : r1;
    comp0 = r0 && !ew0;
    comp1 = r1 && !ew1;
    chk("gnt", 64'(arb_gnt), 64'(eg));
    chk("bso", 64'({bso_wen, bso_ren, bso_adr, bso_wdt}), 64'(eb));
    chk("wrq", 64'({m1_wrq, m0_wrq}), 64'({ew1, ew0}));
    chk("rdt", {m1_rdt, m0_rdt}, {bso_rdt, bso_rdt});
    @(posedge clk);
    if (!rst) begin
      own = -1; used = 0; last = 1;
    end else if (own < 0) begin
      if (r0 || r1) begin
        own  = (r0 && r1) ? (RR_MODE ? 1 - last : 0) : (r0 ? 0 : 1);
        used = 0;
        last = own;
      end
    end else begin
      x = own;
      if (!(x == 0 ? r0 : r1)) begin
        used = 0;
        if (x == 0 ? r1 : r0) begin own = 1 - x; last = own; end
        else own = -1;
      end else if (!bso_wrq) begin
        used++;
        if (used == BURST) begin
          used = 0;
          if (budget(x) && (x == 0 ? r1 : r0)) begin own = 1 - x; last = own; end
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic idle_all();
    m0_wen = 0; m0_ren = 0; m1_wen = 0; m1_ren = 0;
  endtask

  initial begin
    rst = 1'b0;
    m0_wen = 0; m0_ren = 1; m0_adr = 24'h000020; m0_wdt = 32'h0;
    m1_wen = 0; m1_ren = 1; m1_adr = 24'h000040; m1_wdt = 32'h0;
    bso_rdt = 32'h0; bso_wrq = 1'b1;

    // Reset with both requesting.
    repeat (3) step();
    chk("rst_gnt", 64'(arb_gnt), 64'd0);
    chk("rst_bso", 64'({bso_wen, bso_ren}), 64'd0);
    chk("rst_wrq", 64'({m1_wrq, m0_wrq}), 64'b11);
    rst = 1'b1;
    step();
    chk("rst_first_gnt", 64'(arb_gnt), 64'b01);
    idle_all();
    step();

    // Single read by m1 with two wait cycles.
    do_reset();
    m1_ren = 1; m1_adr = 24'h000100; bso_rdt = 32'hDEADBEEF; bso_wrq = 1;
    step();
    chk("rd_gnt", 64'(arb_gnt), 64'b10);
    chk("rd_adr", 64'(bso_adr), 64'h100);
    chk("rd_wrq1", 64'(m1_wrq), 64'd1);
    step();
    chk("rd_wrq2", 64'(m1_wrq), 64'd1);
    bso_wrq = 0;
    #1;
    chk("rd_wrq_done", 64'(m1_wrq), 64'd0);
    chk("rd_rdt", 64'(m1_rdt), 64'hDEADBEEF);
    step();
    idle_all();
    step();

    // Budget: m1 streams, m0 joins after m1's first completion.
    do_reset();
    m1_ren = 1; m1_adr = 24'h000200; bso_wrq = 0;
    step();
    step();
    m0_wen = 1; m0_adr = 24'h000010; m0_wdt = 32'h12345678;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bud_m1_owns", 64'(arb_gnt), 64'b10);
    end
    step();
    chk("bud_handover", 64'(arb_gnt), 64'b01);
    chk("bud_bso", 64'({bso_wen, bso_adr, bso_wdt}), {7'd0, 1'b1, 24'h000010, 32'h12345678});
    chk("bud_m1_wait", 64'(m1_wrq), 64'd1);
    step();
    m0_wen = 0;
    step();
    chk("bud_back_m1", 64'(arb_gnt), 64'b10);
    idle_all();
    step();

    // Ties from IDLE, twice with idle gaps.
    do_reset();
    bso_wrq = 0;
    m0_ren = 1; m1_ren = 1;
    step();
    chk("tie1", 64'(arb_gnt), 64'b01);
    step();
    idle_all();
    step();
    step();
    m0_ren = 1; m1_ren = 1;
    step();
    chk("tie2", 64'(arb_gnt), RR_MODE ? 64'b10 : 64'b01);
    idle_all();
    step();
    step();

    // m0 continuous writes with m1 pending.
    do_reset();
    m0_wen = 1; m0_adr = 24'h000030; m1_ren = 1; bso_wrq = 0;
    step();
    for (int i = 0; i < 22; i++) begin
`ifndef SOCKIT_SPI_ARB_RR_EN
      chk("starve_wrq", 64'(m1_wrq), 64'd1);
      chk("starve_gnt", 64'(arb_gnt), 64'b01);
`endif
      step();
    end
    idle_all();
    step();

    // Reset in the middle of a stalled m0 transfer.
    do_reset();
    m0_wen = 1; m0_adr = 24'h000044; bso_wrq = 1;
    step();
    chk("mid_gnt", 64'(arb_gnt), 64'b01);
    rst = 0;
    step();
    rst = 1;
    #1;
    chk("mid_idle_gnt", 64'(arb_gnt), 64'd0);
    chk("mid_idle_wen", 64'(bso_wen), 64'd0);
    chk("mid_idle_wrq", 64'(m0_wrq), 64'd1);
    step();
    chk("mid_regrant", 64'(arb_gnt), 64'b01);
    idle_all();
    step();

    // Randomized traffic obeying the hold-while-stalled rule.
    for (int n = 0; n < 2000; n++) begin
      bso_wrq = ($urandom_range(0, 1) == 1);
      bso_rdt = $urandom;
      rst     = ($urandom_range(0, 99) != 0);
      step();
      if (!((m0_wen | m0_ren) && !comp0)) begin
        if ($urandom_range(0, 99) < 60) begin
          m0_wen = $urandom_range(0, 1); m0_ren = ~m0_wen;
          m0_adr = BAW'($urandom); m0_wdt = $urandom;
        end else begin
          m0_wen = 0; m0_ren = 0;
        end
      end
      if (!((m1_wen | m1_ren) && !comp1)) begin
        if ($urandom_range(0, 99) < 60) begin
          m1_wen = $urandom_range(0, 1); m1_ren = ~m1_wen;
          m1_adr = BAW'($urandom); m1_wdt = $urandom;
        end else begin
          m1_wen = 0; m1_ren = 0;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
